// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: widths, exception codes and buffer entry layout shared by the fetch stage
package fetch_unit_pkg;
  localparam int ADDR_SIZE = 31;
  localparam int INSTR_SIZE = 31;
  localparam int EX_WIDTH = 3;
  localparam logic [EX_WIDTH:0] EX_INSTR_ADDR_MISALIGN = 4'd0;
  localparam logic [INSTR_SIZE:0] INSTR_NOP = 32'h0000_0013;
  typedef enum logic {RUN, HALT} state_t;
  typedef struct packed {
    logic [ADDR_SIZE:0] pc;
    logic [INSTR_SIZE:0] instr;
    logic ex_valid;
    logic [EX_WIDTH:0] ex_code;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear; a push into a full FIFO is taken when a pop happens in the same cycle
module fetch_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
)(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= inc(wr);
      end
      if (do_pop) rd <= inc(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order instruction fetches into a small buffer,
// redirects on flush and traps misaligned PCs with a NOP entry
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_SIZE:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
)(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic [ADDR_SIZE:0] flush_addr,
  output logic imem_req,
  output logic [ADDR_SIZE:0] imem_addr,
  input  logic imem_gnt,
  input  logic imem_rvalid,
  input  logic [INSTR_SIZE:0] imem_rdata,
  output logic if_valid,
  input  logic if_ready,
  output logic [ADDR_SIZE:0] if_pc,
  output logic [INSTR_SIZE:0] if_instr,
  output logic if_exception_valid,
  output logic [EX_WIDTH:0] if_exception
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state;
  logic [ADDR_SIZE:0] fetch_pc, pcq_head;
  logic [CW-1:0] outstanding, drop_cnt, buf_count, pcq_count;
  logic buf_empty, buf_full, pcq_empty, pcq_full;
  logic gnt_fire, keep, misalign, pop, unused_pcq;
  entry_t buf_in, buf_out, head;
  assign gnt_fire = imem_req && imem_gnt;
  assign keep = imem_rvalid && drop_cnt == '0 && !flush && !pcq_empty;
  assign misalign = state == RUN && fetch_pc[1:0] != 2'b00 && outstanding == '0 && !buf_full && !flush;
  assign pop = if_valid && if_ready;
  // credit counts only registered occupancy, so a same-cycle pop never frees a slot early
  assign imem_req = !reset && state == RUN && fetch_pc[1:0] == 2'b00 && !pcq_full &&
                    ({1'b0, outstanding} + {1'b0, buf_count}) < (CW+1)'(FIFO_DEPTH);
  assign imem_addr = fetch_pc;
  assign buf_in = misalign ? entry_t'{pc: fetch_pc, instr: INSTR_NOP, ex_valid: 1'b1, ex_code: EX_INSTR_ADDR_MISALIGN}
                           : entry_t'{pc: pcq_head, instr: imem_rdata, ex_valid: 1'b0, ex_code: '0};
  assign head = buf_empty ? '0 : buf_out;
  assign if_valid = !buf_empty;
  assign if_pc = head.pc;
  assign if_instr = head.instr;
  assign if_exception_valid = head.ex_valid;
  assign if_exception = head.ex_code;
  assign unused_pcq = ^pcq_count;
  fetch_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk(clk), .reset(reset), .clear(flush), .push(keep || misalign), .pop(pop),
    .din(buf_in), .dout(buf_out), .full(buf_full), .empty(buf_empty), .count(buf_count)
  );
  fetch_fifo #(.W(ADDR_SIZE + 1), .DEPTH(FIFO_DEPTH)) u_pcq (
    .clk(clk), .reset(reset), .clear(flush), .push(gnt_fire && !flush), .pop(keep),
    .din(fetch_pc), .dout(pcq_head), .full(pcq_full), .empty(pcq_empty), .count(pcq_count)
  );
  // after a flush every response still owed by memory belongs to the old stream
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      state <= RUN;
    end else begin
      outstanding <= outstanding + CW'(gnt_fire) - CW'(imem_rvalid);
      if (flush) begin
        fetch_pc <= flush_addr;
        state <= RUN;
        drop_cnt <= outstanding + CW'(gnt_fire) - CW'(imem_rvalid);
      end else begin
        if (gnt_fire) fetch_pc <= fetch_pc + (ADDR_SIZE+1)'(4);
        if (misalign) state <= HALT;
        if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
endmodule
